// File: rtl/step_scheduler.sv
// step_scheduler: tile-based character movement sequencer.
// Turns toward the held direction key, asks the tile-map reader whether the
// next tile is solid, then either walks one tile over 16 frame ticks or plays
// an 8-tick bump.
//
// Ports:
//   Clk, Reset         clock, asynchronous active-high reset
//   frame_tick         one-cycle pulse per video frame
//   enable             main-game state active
//   dir_valid/dir_req  held direction key (0 down, 1 up, 2 left, 3 right)
//   col_req/col_x/col_y  collision lookup request and target tile
//   col_ack/col_blocked  lookup response (blocked valid with ack)
//   tile_x/tile_y      current tile
//   direction          facing direction
//   moving/step_offset step in progress and pixel offset 0..15
//   anim_frame         walk sprite frame
module step_scheduler #(
  parameter int MAP_W       = 32,
  parameter int MAP_H       = 32,
  parameter int START_X     = 8,
  parameter int START_Y     = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       dir_valid,
  input  logic [1:0] dir_req,
  output logic       col_req,
  output logic [5:0] col_x,
  output logic [5:0] col_y,
  input  logic       col_ack,
  input  logic       col_blocked,
  output logic [5:0] tile_x,
  output logic [5:0] tile_y,
  output logic [1:0] direction,
  output logic       moving,
  output logic [3:0] step_offset,
  output logic [1:0] anim_frame
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [5:0] X_MAX = 6'(MAP_W - 1);
  localparam logic [5:0] Y_MAX = 6'(MAP_H - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, STEP, BUMP} state_t;

  state_t        state, state_d;
  logic [5:0]    tile_x_d, tile_y_d, col_x_d, col_y_d;
  logic [1:0]    dir_d;
  logic [3:0]    off_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]    bump_cnt, bump_d;
  logic [5:0]    tgt_x, tgt_y;
  logic          off_map;

  // Neighbouring tile in the facing direction and whether it leaves the map.
  always_comb begin
    tgt_x   = tile_x;
    tgt_y   = tile_y;
    off_map = 1'b0;
    case (direction)
      2'd0: begin off_map = (tile_y == Y_MAX); tgt_y = tile_y + 6'd1; end
      2'd1: begin off_map = (tile_y == '0);    tgt_y = tile_y - 6'd1; end
      2'd2: begin off_map = (tile_x == '0);    tgt_x = tile_x - 6'd1; end
      default: begin off_map = (tile_x == X_MAX); tgt_x = tile_x + 6'd1; end
    endcase
  end

  // col_x/col_y hold the target for the whole lookup and the following step;
  // the step commits from them so no separate target register is needed.
  always_comb begin
    state_d  = state;
    tile_x_d = tile_x;
    tile_y_d = tile_y;
    col_x_d  = col_x;
    col_y_d  = col_y;
    dir_d    = direction;
    off_d    = step_offset;
    timer_d  = timer;
    bump_d   = bump_cnt;
    case (state)
      IDLE: begin
        if (frame_tick && enable && dir_valid) begin
          if (dir_req != direction) begin
            dir_d = dir_req;
          end else if (off_map) begin
            state_d = BUMP;
            bump_d  = '0;
          end else begin
            state_d = LOOKUP;
            col_x_d = tgt_x;
            col_y_d = tgt_y;
            timer_d = '0;
          end
        end
      end
      LOOKUP: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (col_ack) begin
          state_d = col_blocked ? BUMP : STEP;
          bump_d  = '0;
          off_d   = '0;
        end else if (timer == T_LAST) begin
          state_d = BUMP;
          bump_d  = '0;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      STEP: begin
        if (frame_tick) begin
          if (step_offset == 4'd15) begin
            tile_x_d = col_x;
            tile_y_d = col_y;
            off_d    = '0;
            state_d  = IDLE;
          end else begin
            off_d = step_offset + 4'd1;
          end
        end
      end
      default: begin // BUMP
        if (!enable) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          if (bump_cnt == 3'd7) state_d = IDLE;
          else                  bump_d  = bump_cnt + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      tile_x      <= 6'(START_X);
      tile_y      <= 6'(START_Y);
      col_x       <= '0;
      col_y       <= '0;
      direction   <= 2'd1;
      step_offset <= '0;
      timer       <= '0;
      bump_cnt    <= '0;
    end else begin
      state       <= state_d;
      tile_x      <= tile_x_d;
      tile_y      <= tile_y_d;
      col_x       <= col_x_d;
      col_y       <= col_y_d;
      direction   <= dir_d;
      step_offset <= off_d;
      timer       <= timer_d;
      bump_cnt    <= bump_d;
    end
  end

  // Decoded from state so that reset drops col_req asynchronously.
  assign col_req = (state == LOOKUP);
  assign moving  = (state == STEP);

  always_comb begin
    anim_frame = '0;
    if (state == STEP) begin
      case (step_offset[3:2])
        2'd0:    anim_frame = 2'd0;
        2'd1:    anim_frame = 2'd1;
        2'd2:    anim_frame = 2'd2;
        default: anim_frame = 2'd1;
      endcase
    end
  end

endmodule
